// File: rtl/irqctl.sv
// irqctl: prioritised interrupt controller for the 6801 system bus
// Ports: clk system clock; rst asynchronous active-low reset; irq registered CPU request;
//        AD/DI/DO/rw/cs 8-register slave bus; src raw asynchronous interrupt sources.
// Build option IRQCTL_EDGE_EN adds edge mode, edge flags, FORCE and PEND write-1-clear.
module irqctl #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                irq,
    input  logic [2:0]          AD,
    input  logic [7:0]          DI,
    output logic [7:0]          DO,
    input  logic                rw,
    input  logic                cs,
    input  logic [CHANNELS-1:0] src
);
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] s, en, mode, pend, pe;
    logic                gie, wr;
    logic [2:0]          idx;
    logic [7:0]          rd;
    assign s  = sync[SYNC_STAGES-1];
    assign wr = cs & ~rw;
    assign pe = pend & en;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync <= '0;
            en   <= '0;
            gie  <= 1'b0;
            irq  <= 1'b0;
        end else begin
            sync[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            if (wr && AD == 3'd2) en <= DI[CHANNELS-1:0];
            if (wr && AD == 3'd5) gie <= DI[0];
            irq <= gie & |pe;
        end
`ifdef IRQCTL_EDGE_EN
    logic [CHANNELS-1:0] s_prev, flag, mode_n, frc, clr;
    assign mode_n = (wr && AD == 3'd3) ? DI[CHANNELS-1:0] : mode;
    assign frc    = (wr && AD == 3'd6) ? DI[CHANNELS-1:0] : '0;
    assign clr    = (wr && AD == 3'd1) ? DI[CHANNELS-1:0] : '0;
    assign pend   = (mode & flag) | (~mode & s);
    // set terms are ORed after the clear so a coincident edge wins; masking
    // with the next MODE drops flags of channels leaving edge mode
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s_prev <= '0;
            flag   <= '0;
            mode   <= '0;
        end else begin
            s_prev <= s;
            mode   <= mode_n;
            flag   <= ((flag & ~clr) | (s & ~s_prev) | frc) & mode_n;
        end
`else
    assign mode = '0;
    assign pend = s;
`endif
    // scan downwards so the lowest-numbered pending channel ends up in idx
    always_comb begin
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) if (pe[i]) idx = 3'(i);
    end
    always_comb begin
        case (AD)
            3'd0:    rd = 8'(s);
            3'd1:    rd = 8'(pend);
            3'd2:    rd = 8'(en);
            3'd3:    rd = 8'(mode);
            3'd4:    rd = {gie & |pe, 4'b0000, idx};
            3'd5:    rd = {7'b0, gie};
            default: rd = 8'h00;
        endcase
        DO = (cs && rw) ? rd : 8'h00;
    end
endmodule

// File: tb/tb_irqctl.sv
// tb_irqctl: directed scoreboard bench for irqctl (8-channel and 3-channel builds)
module tb_irqctl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       irq, irq3, rw = 1'b1, cs = 1'b0;
    logic [2:0] AD = 3'd0;
    logic [7:0] DI = 8'h00, DO, DO3, v, v3;
    logic [7:0] src = 8'hFF;
    logic [2:0] src3 = 3'b000;
    int         checks = 0, fails = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    irqctl dut (.clk(clk), .rst(rst), .irq(irq), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .src(src));
    irqctl #(.CHANNELS(3)) dut3 (.clk(clk), .rst(rst), .irq(irq3), .AD(AD), .DI(DI), .DO(DO3), .rw(rw), .cs(cs), .src(src3));

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [7:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed 0x%02h expected none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s observed 0x%02h expected 0x%02h", t, obs, e);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(posedge clk);
        #1;
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d, output logic [7:0] d3);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1;
        d = DO; d3 = DO3;
        cs = 1'b0;
    endtask

    initial begin
        repeat (3) tick;
        push("rst_irq", 8'h00);     check({7'b0, irq});
        push("rst_enable", 8'h00);  rd(3'd2, v, v3); check(v);
        push("rst_ctrl", 8'h00);    rd(3'd5, v, v3); check(v);
        push("rst_vec7", 8'h00);    rd(3'd4, v, v3); check(v & 8'h80);
        push("rst_status", 8'h00);  rd(3'd0, v, v3); check(v);
        src = 8'h00;
        rst = 1'b1;
        repeat (3) tick;

        wr(3'd2, 8'h0C);
        wr(3'd5, 8'h01);
        src = 8'h0C;
        tick; tick;
        push("lvl_irq_early", 8'h00); check({7'b0, irq});
        tick;
        push("lvl_irq_3cyc", 8'h01);  check({7'b0, irq});
        push("lvl_status", 8'h0C);    rd(3'd0, v, v3); check(v);
        push("lvl_vec_82", 8'h82);    rd(3'd4, v, v3); check(v);
        src = 8'h08;
        tick; tick;
        push("lvl_vec_83", 8'h83);    rd(3'd4, v, v3); check(v);
        src = 8'h00;
        tick; tick;
        push("lvl_irq_hold", 8'h01);  check({7'b0, irq});
        tick;
        push("lvl_irq_drop", 8'h00);  check({7'b0, irq});

        src = 8'h01;
        wr(3'd2, 8'h01);
        repeat (4) tick;
        push("mid_irq_before", 8'h01); check({7'b0, irq});
        #2 rst = 1'b0;
        #2;
        push("mid_irq_fall", 8'h00);   check({7'b0, irq});
        push("mid_enable", 8'h00);     rd(3'd2, v, v3); check(v);
        push("mid_ctrl", 8'h00);       rd(3'd5, v, v3); check(v);
        push("mid_vector", 8'h00);     rd(3'd4, v, v3); check(v);
        rst = 1'b1;
        src = 8'h00;
        tick;
        push("mid_irq_release", 8'h00); check({7'b0, irq});
        tick;

`ifdef IRQCTL_EDGE_EN
        wr(3'd3, 8'h01);
        wr(3'd2, 8'h01);
        wr(3'd5, 8'h01);
        src = 8'h01;
        tick;
        src = 8'h00;
        repeat (3) tick;
        push("edge_irq", 8'h01);       check({7'b0, irq});
        push("edge_pend", 8'h01);      rd(3'd1, v, v3); check(v);
        src = 8'h01;
        tick;
        src = 8'h00;
        tick;
        wr(3'd1, 8'h01);
        push("edge_set_wins", 8'h01);  rd(3'd1, v, v3); check(v);
        wr(3'd1, 8'h01);
        push("edge_irq_hold", 8'h01);  check({7'b0, irq});
        tick;
        push("edge_irq_clr", 8'h00);   check({7'b0, irq});
        push("edge_pend_clr", 8'h00);  rd(3'd1, v, v3); check(v);

        wr(3'd3, 8'h80);
        wr(3'd2, 8'h80);
        wr(3'd6, 8'hFF);
        push("force_pend", 8'h80);     rd(3'd1, v, v3); check(v);
        push("force_vec", 8'h87);      rd(3'd4, v, v3); check(v);
        push("force_read", 8'h00);     rd(3'd6, v, v3); check(v);
        wr(3'd3, 8'h00);
        wr(3'd3, 8'h80);
        push("mode_discard", 8'h00);   rd(3'd1, v, v3); check(v);
        wr(3'd3, 8'h00);
`else
        wr(3'd3, 8'hFF);
        push("mode_ro", 8'h00);        rd(3'd3, v, v3); check(v);
        wr(3'd2, 8'h01);
        wr(3'd5, 8'h01);
        wr(3'd6, 8'hFF);
        push("force_ignored", 8'h00);  rd(3'd1, v, v3); check(v);
        tick;
        push("force_no_irq", 8'h00);   check({7'b0, irq});
        push("force_read", 8'h00);     rd(3'd6, v, v3); check(v);
`endif

        wr(3'd2, 8'hFF);
        rd(3'd2, v, v3);
        push("c8_enable", 8'hFF);      check(v);
        push("c3_enable", 8'h07);      check(v3);
        rd(3'd7, v, v3);
        push("c8_reg7", 8'h00);        check(v);
        push("c3_reg7", 8'h00);        check(v3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/irqctl.md
# irqctl

Parametrised interrupt controller for the 6801 system bus. Replaces the hard-wired OR of peripheral interrupt lines in front of the CPU `irq` input. Provides per-channel enable, level/edge mode, software trigger, global enable and a priority vector register. Sits in the I/O decode window alongside the other bus peripherals and uses the same 8-register, `cs`/`rw` slave protocol.

## Interface

Parameters:
- `CHANNELS`, default 8: number of interrupt sources, legal range 1..8.
- `SYNC_STAGES`, default 2: depth of the source synchroniser, legal range 1..3.

Ports:
- `clk`, input, 1: system (CPU) clock; all state is updated on the rising edge.
- `rst`, input, 1: reset. **Asynchronous, active-low.** One clock; reset is asynchronous and active-low.
- `irq`, output, 1: registered interrupt request to the CPU, active-high.
- `AD`, input, 3: register select.
- `DI`, input, 8: write data from the CPU.
- `DO`, output, 8: read data to the CPU.
- `rw`, input, 1: 1 = read, 0 = write.
- `cs`, input, 1: chip select, already qualified with `vma`.
- `src`, input, `CHANNELS`: raw interrupt sources, active-high, asynchronous to `clk`.

## Operation

Common rules:
- Each `src[i]` passes through a `SYNC_STAGES`-flop synchroniser to produce `s[i]`.
- Register bits at or above `CHANNELS` read 0, and writes to them are ignored.
- Write: on the `clk` rising edge when `cs` is high and `rw` is low.
- Read: `DO` is combinational from `AD` while `cs` and `rw` are both high; otherwise `DO` = 0x00.

Register map (`AD` value, name, behaviour):
- 0 STATUS (RO): `s`, the synchronised raw levels.
- 1 PEND: read returns `pend`. Writing 1 clears the matching edge-mode bit; writing 0 has no effect.
- 2 ENABLE (RW): per-channel mask.
- 3 MODE (RW): 1 = rising-edge channel, 0 = level channel.
- 4 VECTOR (RO):
  - bit7 = `active` = GIE & |(pend & ENABLE).
  - bits 2:0 = index of the lowest-numbered set bit of pend & ENABLE (channel 0 has highest priority).
  - All bits 0 when nothing is pending and enabled.
  - bit7 is 0 when GIE = 0, but the index field is still valid.
- 5 CTRL (RW): bit0 = GIE. Other bits read 0.
- 6 FORCE (WO): writing 1 sets `pend` for edge-mode channels. Writes to level channels are ignored. Reads as 0.
- 7: reads 0x00; writes are ignored.

Pending logic:
- Level channel: `pend[i]` = `s[i]` (combinational). It cannot be cleared by software.
- Edge channel: `pend[i]` is set on `s[i]` going 0→1 (compared against the previous-cycle `s[i]`) or by FORCE. It is cleared by a PEND write-1. Set has priority over clear in the same cycle.
- Changing MODE from edge to level discards the stored edge flag; the flag register is zeroed for that channel.
- `irq` is registered: `irq` <= GIE & |(pend & ENABLE).

## Timing

- Reset values (asynchronous, while `rst` = 0):
  - `irq` = 0.
  - Synchronisers, edge history and edge flags = 0.
  - ENABLE = 0x00, MODE = 0x00, GIE = 0.
  - `DO` follows the read rule, so reads during reset return register reset values.
- Reset asserted mid-operation clears all state immediately, including a pending `irq`. Release is glitch-free: `irq` stays 0 for at least one cycle after release.
- Source-to-`irq` latency:
  - Level channel: `SYNC_STAGES` + 1 cycles.
  - Edge channel: `SYNC_STAGES` + 2 cycles (edge flag register, then `irq` register).
- Write-to-effect: ENABLE, GIE, PEND-clear and FORCE writes take effect at the write edge; `irq` changes one cycle later.
- The edge detector captures only one event per channel until it is cleared. Pulses shorter than one `clk` period may be missed; this is the source's responsibility.
- A new rising edge in the same cycle as a PEND write-1 clear on that channel leaves the bit set.

## Configuration

- `IRQCTL_EDGE_EN` defined:
  - Edge mode, edge flags, FORCE and PEND write-1-clear are implemented as described.
- `IRQCTL_EDGE_EN` undefined:
  - All channels are level-sensitive.
  - MODE reads 0x00 and ignores writes.
  - FORCE and PEND writes are ignored.
  - Edge flag logic is not synthesised.
  - Level latency is unchanged.

## Test plan

- **Reset:** hold `rst` = 0 with `src` = 0xFF. Require `irq` = 0, ENABLE reads 0x00, CTRL reads 0x00, and VECTOR bit7 = 0.
- **Level priority:** write ENABLE = 0x0C and CTRL = 0x01, then drive `src` = 0x0C.
  - Require `irq` = 1 exactly 3 cycles later (`SYNC_STAGES` = 2) and VECTOR = 0x82.
  - Drop `src[2]`: VECTOR = 0x83.
  - Drop `src[3]`: `irq` = 0 after 3 cycles.
- **Edge with set-beats-clear:** write MODE = 0x01, ENABLE = 0x01, GIE = 1, and pulse `src[0]` for 1 cycle.
  - Require PEND = 0x01 and `irq` = 1.
  - Write PEND = 0x01 in the same cycle as a new synchronised edge: PEND stays 0x01.
  - Write PEND = 0x01 again: `irq` = 0 one cycle later.
- **FORCE:** with MODE = 0x80 and ENABLE = 0x80, write FORCE = 0xFF.
  - Require PEND = 0x80 (level bits untouched) and VECTOR = 0x87.
- **Mid-operation reset:** with `irq` = 1, pulse `rst` low between clock edges. Require `irq` to fall before the next edge and all registers to read their reset values.
- **`CHANNELS` = 3 build:** write ENABLE = 0xFF. Require readback 0x07 and register 7 = 0x00.
